// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and width defaults for mem_arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_WAIT = 3'd2,
        D_ADDR = 3'd3,
        D_WAIT = 3'd4
    } arbState_t;

endpackage

// File: rtl/mem_arb_slot.sv
// rtl/mem_arb_slot.sv - per-requester done flag and response buffer
module mem_arb_slot
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              capture,
    input  logic              loadBuf,
    input  logic [DATA_W-1:0] respData,
    output logic              done,
    output logic [DATA_W-1:0] respBuf
);

    // Done flag: a pipeline advance always wins so a request is serviced once per advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= 1'b0;
        end else if (advance) begin
            done <= 1'b0;
        end else if (capture) begin
            done <= 1'b1;
        end
    end

    // Response buffer: only loaded on completion of an access that returns data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            respBuf <= '0;
        end else if (capture && loadBuf) begin
            respBuf <= respData;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single request/response memory bus
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              i_stall,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arbState_t state;
    arbState_t nextState;
    logic      iDone;
    logic      dDone;
    logic      iCapture;
    logic      dCapture;
    logic      startData;
    logic      startInst;
    logic      addrAccepted;
    logic      accessWr;
    logic      advance;

    assign advance = ~longest_stall;
    assign i_stall = inst_req & ~iDone;
    assign d_stall = data_en & ~dDone;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus one-cycle strobes; data wins over fetch, data_ok only counts in *_WAIT
    always_comb begin
        nextState    = state;
        iCapture     = 1'b0;
        dCapture     = 1'b0;
        startData    = 1'b0;
        startInst    = 1'b0;
        addrAccepted = 1'b0;
        case (state)
            IDLE: begin
                if (data_en && !dDone) begin
                    nextState = D_ADDR;
                    startData = 1'b1;
                end else if (inst_req && !iDone) begin
                    nextState = I_ADDR;
                    startInst = 1'b1;
                end
            end
            I_ADDR: begin
                if (bus_addr_ok) begin
                    nextState    = I_WAIT;
                    addrAccepted = 1'b1;
                end
            end
            I_WAIT: begin
                if (bus_data_ok) begin
                    nextState = IDLE;
                    iCapture  = 1'b1;
                end
            end
            D_ADDR: begin
                if (bus_addr_ok) begin
                    nextState    = D_WAIT;
                    addrAccepted = 1'b1;
                end
            end
            D_WAIT: begin
                if (bus_data_ok) begin
                    nextState = IDLE;
                    dCapture  = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Request channel: fields latched on entry to *_ADDR, request dropped once accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= 4'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            accessWr  <= 1'b0;
        end else if (startData) begin
            bus_req   <= 1'b1;
            bus_wr    <= |data_wen;
            bus_wstrb <= data_wen;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            accessWr  <= |data_wen;
        end else if (startInst) begin
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= 4'b0;
            bus_addr  <= inst_addr;
        end else if (addrAccepted) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= 4'b0;
        end
    end

    mem_arb_slot #(.DATA_W(DATA_W)) instSlot (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .capture  (iCapture),
        .loadBuf  (1'b1),
        .respData (bus_rdata),
        .done     (iDone),
        .respBuf  (inst_rdata)
    );

    // Stores complete the slot but leave the load buffer untouched
    mem_arb_slot #(.DATA_W(DATA_W)) dataSlot (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .capture  (dCapture),
        .loadBuf  (~accessWr),
        .respData (bus_rdata),
        .done     (dDone),
        .respBuf  (data_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam logic [31:0] MASK = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        hazard;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int passCnt = 0;
    int totalCnt = 0;

    // bus slave model state and transaction log
    int          addrDelay = 0;
    int          dataDelay = 0;
    int          addrCnt = 0;
    int          waitCnt = 0;
    bit          waiting = 0;
    bit          inReq = 0;
    bit          unstable = 0;
    int          nReq = 0;
    int          reqCycles = 0;
    logic [31:0] firstAddr;
    logic [31:0] firstWdata;
    logic [31:0] pendAddr;
    logic [31:0] logAddr [64];
    logic [31:0] logWdata [64];
    logic        logWr [64];
    logic [3:0]  logWstrb [64];

    // pipeline model: the whole pipe stalls on a hazard or on either memory stall
    assign longest_stall = hazard | i_stall | d_stall;

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_en       (data_en),
        .data_wen      (data_wen),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_wstrb     (bus_wstrb),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // bus slave: answers on the falling edge, read data = address ^ MASK
    initial begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (waiting) begin
                if (waitCnt == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = pendAddr ^ MASK;
                    waiting     = 1'b0;
                end else begin
                    waitCnt = waitCnt - 1;
                end
            end else if (bus_req) begin
                if (!inReq) begin
                    inReq      = 1'b1;
                    firstAddr  = bus_addr;
                    firstWdata = bus_wdata;
                end else if (bus_addr !== firstAddr || bus_wdata !== firstWdata) begin
                    unstable = 1'b1;
                end
                reqCycles = reqCycles + 1;
                if (addrCnt == addrDelay) begin
                    bus_addr_ok    = 1'b1;
                    logAddr[nReq]  = bus_addr;
                    logWdata[nReq] = bus_wdata;
                    logWr[nReq]    = bus_wr;
                    logWstrb[nReq] = bus_wstrb;
                    nReq           = nReq + 1;
                    pendAddr       = bus_addr;
                    waiting        = 1'b1;
                    waitCnt        = dataDelay;
                    addrCnt        = 0;
                    inReq          = 1'b0;
                end else begin
                    addrCnt = addrCnt + 1;
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0000;
        repeat (2) @(negedge clk);
        #1;
        totalCnt++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req: got %b expected 0", bus_req); else passCnt++;
        totalCnt++; if (bus_addr !== 32'h0) $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); else passCnt++;
        totalCnt++; if ({bus_wr, bus_wstrb} !== 5'b0) $display("FAIL reset_bus_wr: got %b expected 0", {bus_wr, bus_wstrb}); else passCnt++;
        totalCnt++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); else passCnt++;
        inst_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int base;
        int stallCnt;
        base = nReq;
        stallCnt = 0;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        for (int k = 0; k < 10 && i_stall; k++) begin
            stallCnt++;
            @(negedge clk);
            #1;
        end
        totalCnt++; if (stallCnt !== 3) $display("FAIL fetch_stall_cycles: got %0d expected 3", stallCnt); else passCnt++;
        totalCnt++; if (nReq - base !== 1) $display("FAIL fetch_req_count: got %0d expected 1", nReq - base); else passCnt++;
        totalCnt++; if (logAddr[base] !== 32'hBFC0_0000 || logWr[base] !== 1'b0 || logWstrb[base] !== 4'b0) $display("FAIL fetch_bus_fields: got %h/%b/%b expected bfc00000/0/0000", logAddr[base], logWr[base], logWstrb[base]); else passCnt++;
        totalCnt++; if (inst_rdata !== (32'hBFC0_0000 ^ MASK)) $display("FAIL fetch_rdata: got %h expected %h", inst_rdata, 32'hBFC0_0000 ^ MASK); else passCnt++;
        inst_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int base;
        int dFall;
        int iFall;
        base = nReq;
        dFall = -1;
        iFall = -1;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0004;
        data_en = 1'b1;
        data_wen = 4'b0000;
        data_addr = 32'h8000_1000;
        #1;
        for (int k = 0; k < 15; k++) begin
            if (dFall < 0 && !d_stall) dFall = k;
            if (iFall < 0 && !i_stall) iFall = k;
            if (dFall >= 0 && iFall >= 0) break;
            @(negedge clk);
            #1;
        end
        totalCnt++; if (dFall !== 3 || iFall !== 6) $display("FAIL prio_stall_fall: got d=%0d i=%0d expected d=3 i=6", dFall, iFall); else passCnt++;
        totalCnt++; if (logAddr[base] !== 32'h8000_1000 || logWr[base] !== 1'b0) $display("FAIL prio_first_req: got %h wr=%b expected 80001000 wr=0", logAddr[base], logWr[base]); else passCnt++;
        totalCnt++; if (nReq - base !== 2 || logAddr[base+1] !== 32'hBFC0_0004) $display("FAIL prio_second_req: got n=%0d %h expected n=2 bfc00004", nReq - base, logAddr[base+1]); else passCnt++;
        totalCnt++; if (data_rdata !== (32'h8000_1000 ^ MASK)) $display("FAIL prio_data_rdata: got %h expected %h", data_rdata, 32'h8000_1000 ^ MASK); else passCnt++;
        totalCnt++; if (inst_rdata !== (32'hBFC0_0004 ^ MASK)) $display("FAIL prio_inst_rdata: got %h expected %h", inst_rdata, 32'hBFC0_0004 ^ MASK); else passCnt++;
        inst_req = 1'b0;
        data_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        int base;
        int stallCnt;
        base = nReq;
        stallCnt = 0;
        data_en = 1'b1;
        data_wen = 4'b0011;
        data_addr = 32'h8000_2000;
        data_wdata = 32'h1234_5678;
        #1;
        for (int k = 0; k < 10 && d_stall; k++) begin
            stallCnt++;
            @(negedge clk);
            #1;
        end
        totalCnt++; if (stallCnt !== 3) $display("FAIL store_stall_cycles: got %0d expected 3", stallCnt); else passCnt++;
        totalCnt++; if (logWr[base] !== 1'b1 || logWstrb[base] !== 4'b0011) $display("FAIL store_wr_wstrb: got %b/%b expected 1/0011", logWr[base], logWstrb[base]); else passCnt++;
        totalCnt++; if (logAddr[base] !== 32'h8000_2000 || logWdata[base] !== 32'h1234_5678) $display("FAIL store_addr_wdata: got %h/%h expected 80002000/12345678", logAddr[base], logWdata[base]); else passCnt++;
        totalCnt++; if (data_rdata !== (32'h8000_1000 ^ MASK)) $display("FAIL store_rdata_kept: got %h expected %h", data_rdata, 32'h8000_1000 ^ MASK); else passCnt++;
        data_en = 1'b0;
        data_wen = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fetch_hold();
        int base;
        int nFetch;
        bit holdErr;
        logic [31:0] held;
        base = nReq;
        nFetch = 0;
        holdErr = 1'b0;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0008;
        @(negedge clk);
        data_en = 1'b1;
        data_wen = 4'b0000;
        data_addr = 32'h8000_3000;
        #1;
        for (int k = 0; k < 10 && i_stall; k++) begin
            @(negedge clk);
            #1;
        end
        held = inst_rdata;
        totalCnt++; if (held !== (32'hBFC0_0008 ^ MASK) || d_stall !== 1'b1) $display("FAIL hold_fetch_first: got %h d_stall=%b expected %h d_stall=1", held, d_stall, 32'hBFC0_0008 ^ MASK); else passCnt++;
        for (int k = 0; k < 10 && d_stall; k++) begin
            @(negedge clk);
            #1;
            if (inst_rdata !== held || i_stall !== 1'b0) holdErr = 1'b1;
        end
        hazard = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (inst_rdata !== held || i_stall !== 1'b0 || d_stall !== 1'b0) holdErr = 1'b1;
        end
        for (int i = base; i < nReq; i++) begin
            if (logWr[i] == 1'b0 && logAddr[i] == 32'hBFC0_0008) nFetch++;
        end
        totalCnt++; if (nFetch !== 1) $display("FAIL hold_single_fetch: got %0d expected 1", nFetch); else passCnt++;
        totalCnt++; if (nReq - base !== 2) $display("FAIL hold_bus_reqs: got %0d expected 2", nReq - base); else passCnt++;
        totalCnt++; if (holdErr !== 1'b0) $display("FAIL hold_stable: got err=%b expected 0", holdErr); else passCnt++;
        totalCnt++; if (data_rdata !== (32'h8000_3000 ^ MASK)) $display("FAIL hold_data_rdata: got %h expected %h", data_rdata, 32'h8000_3000 ^ MASK); else passCnt++;
        hazard = 1'b0;
        inst_req = 1'b0;
        data_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_delay();
        int base;
        int rc0;
        int stallCnt;
        base = nReq;
        rc0 = reqCycles;
        stallCnt = 0;
        addrDelay = 4;
        data_en = 1'b1;
        data_wen = 4'b1111;
        data_addr = 32'h8000_4000;
        data_wdata = 32'hCAFE_F00D;
        #1;
        stallCnt++;
        @(negedge clk);
        #1;
        stallCnt++;
        @(negedge clk);
        data_addr = 32'h1111_1111;
        data_wdata = 32'h2222_2222;
        #1;
        for (int k = 0; k < 20 && d_stall; k++) begin
            stallCnt++;
            @(negedge clk);
            #1;
        end
        totalCnt++; if (reqCycles - rc0 !== 5) $display("FAIL delay_req_cycles: got %0d expected 5", reqCycles - rc0); else passCnt++;
        totalCnt++; if (unstable !== 1'b0) $display("FAIL delay_fields_stable: got unstable=%b expected 0", unstable); else passCnt++;
        totalCnt++; if (logAddr[base] !== 32'h8000_4000 || logWdata[base] !== 32'hCAFE_F00D || logWstrb[base] !== 4'b1111) $display("FAIL delay_fields: got %h/%h/%b expected 80004000/cafef00d/1111", logAddr[base], logWdata[base], logWstrb[base]); else passCnt++;
        totalCnt++; if (stallCnt !== 7) $display("FAIL delay_stall_cycles: got %0d expected 7", stallCnt); else passCnt++;
        addrDelay = 0;
        data_en = 1'b0;
        data_wen = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stallCnt;
        stallCnt = 0;
        dataDelay = 2;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0010;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        inst_req = 1'b0;
        #1;
        totalCnt++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wr !== 1'b0 || bus_wstrb !== 4'b0) $display("FAIL midrst_bus: got req=%b addr=%h wdata=%h expected all 0", bus_req, bus_addr, bus_wdata); else passCnt++;
        totalCnt++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) $display("FAIL midrst_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        totalCnt++; if (inst_rdata !== 32'h0 || bus_req !== 1'b0) $display("FAIL midrst_stale_ignored: got rdata=%h req=%b expected 0/0", inst_rdata, bus_req); else passCnt++;
        dataDelay = 0;
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0014;
        #1;
        totalCnt++; if (i_stall !== 1'b1) $display("FAIL midrst_no_done: got i_stall=%b expected 1", i_stall); else passCnt++;
        for (int k = 0; k < 10 && i_stall; k++) begin
            stallCnt++;
            @(negedge clk);
            #1;
        end
        totalCnt++; if (stallCnt !== 3 || logAddr[nReq-1] !== 32'hBFC0_0014) $display("FAIL midrst_refetch: got %0d cycles addr %h expected 3 bfc00014", stallCnt, logAddr[nReq-1]); else passCnt++;
        totalCnt++; if (inst_rdata !== (32'hBFC0_0014 ^ MASK)) $display("FAIL midrst_rdata_new: got %h expected %h", inst_rdata, 32'hBFC0_0014 ^ MASK); else passCnt++;
        inst_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        hazard = 1'b0;
        inst_req = 1'b0;
        inst_addr = 32'h0;
        data_en = 1'b0;
        data_wen = 4'b0;
        data_addr = 32'h0;
        data_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_fetch_hold();
        test_addr_delay();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: requester and bus address width.
REQ-002 SHALL have parameter DATA_W, default 32: read/write data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port inst_req, input, 1: fetch request, held high by the fetch stage.
REQ-006 SHALL have port inst_addr, input, ADDR_W: fetch address (pcF).
REQ-007 SHALL have port inst_rdata, output, DATA_W: fetched instruction, held in a buffer.
REQ-008 SHALL have port i_stall, output, 1: fetch not yet complete.
REQ-009 SHALL have port data_en, input, 1: data access request (sig_enM).
REQ-010 SHALL have port data_wen, input, 4: byte write strobes; 0 means read.
REQ-011 SHALL have port data_addr, input, ADDR_W: data address.
REQ-012 SHALL have port data_wdata, input, DATA_W: store data.
REQ-013 SHALL have port data_rdata, output, DATA_W: load data, held in a buffer.
REQ-014 SHALL have port d_stall, output, 1: data access not yet complete.
REQ-015 SHALL have port longest_stall, input, 1: pipeline-wide stall from hazard.
REQ-016 SHALL have outputs bus_req (1), bus_wr (1), bus_wstrb (4), bus_addr (ADDR_W), bus_wdata (DATA_W): the shared memory bus request channel.
REQ-017 SHALL have inputs bus_addr_ok (1), bus_data_ok (1), bus_rdata (DATA_W): the bus acceptance and response signals.

Function
REQ-018 SHALL implement FSM states IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
REQ-019 SHALL, in IDLE, go to D_ADDR if data_en & ~d_done, else to I_ADDR if inst_req & ~i_done, else stay in IDLE.
REQ-020 SHALL give data priority over fetch when both are pending in the same cycle.
REQ-021 SHALL register the request fields on entry to *_ADDR and hold them stable until bus_addr_ok.
REQ-022 SHALL drive bus_req=1 only in *_ADDR.
REQ-023 SHALL set bus_wr = |data_wen in D_ADDR, and bus_wr=0 and bus_wstrb=0 in I_ADDR.
REQ-024 SHALL move *_ADDR -> *_WAIT on bus_addr_ok, and *_WAIT -> IDLE on bus_data_ok.
REQ-025 SHALL never expect bus_data_ok earlier than the cycle after bus_addr_ok.
REQ-026 SHALL ignore bus_data_ok in IDLE and *_ADDR.
REQ-027 SHALL, on bus_data_ok in I_WAIT, capture bus_rdata into inst_rdata and set i_done.
REQ-028 SHALL, on bus_data_ok in D_WAIT, set d_done.
REQ-029 SHALL capture bus_rdata into data_rdata in D_WAIT only when the access was a read; data_rdata is unchanged for writes.
REQ-030 SHALL drive i_stall = inst_req & ~i_done and d_stall = data_en & ~d_done, both combinational.
REQ-031 SHALL clear i_done and d_done on any edge where longest_stall=0, so each request is serviced exactly once per pipeline advance.
REQ-032 SHALL hold the done flags and buffers while longest_stall=1 (no refetch, no repeated store).
REQ-033 SHALL have a minimum fetch latency, with addr_ok and data_ok at their earliest, of i_stall high for 3 cycles.

Reset
REQ-034 SHALL, while rst=0, immediately force: state IDLE, i_done=d_done=0, bus_req=0, bus_wr=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, inst_rdata=0, data_rdata=0.
REQ-035 SHALL abandon any transaction in flight when reset is asserted mid-transaction; stale bus_data_ok after reset is ignored per REQ-026.

Structure
REQ-036 SHALL place the FSM state encoding and the ADDR_W/DATA_W defaults in shared package mem_arb_pkg.
REQ-037 SHALL use one sub-module, mem_arb_slot (done flag plus response buffer), instantiated once for fetch and once for data.

Verification
REQ-038 SHALL cover: fetch-only, inst_addr=0xBFC00000, addr_ok same cycle, data_ok +1 -> bus_addr=0xBFC00000, i_stall high exactly 3 cycles, inst_rdata=bus_rdata.
REQ-039 SHALL cover: inst_req and data_en (read, 0x80001000) both high in IDLE -> D_ADDR first, fetch issued only after data_ok, d_stall falls before i_stall.
REQ-040 SHALL cover: store data_wen=4'b0011, wdata=0x12345678 -> bus_wr=1, bus_wstrb=0011, data_rdata unchanged.
REQ-041 SHALL cover: fetch done while data still pending (longest_stall=1) -> exactly one fetch on the bus, inst_rdata stable until longest_stall=0.
REQ-042 SHALL cover: addr_ok delayed 4 cycles -> bus_addr/bus_wdata constant throughout, bus_req high for 5 cycles.
REQ-043 SHALL cover: rst=0 pulse during I_WAIT -> all outputs reset immediately, a subsequent data_ok is ignored, and a fresh fetch issues after release.
